// File: rtl/life_step_engine.sv
// life_step_engine: 8x8 Game of Life generation engine.
// The committed board (cur) feeds the display read port. A generation is
// computed one cell per clock into a shadow bank (nxt) and then committed
// in a single cycle, so the display never sees a partial generation.
//
// Request semantics: load_en and step are single-cycle strobes with no
// ready signal. They are accepted only on a rising edge where the engine
// is idle (busy=0). While busy they are dropped and nothing is queued.
// If load_en and step are both accepted on the same edge, the load lands
// in cur first, so the generation sees the loaded value.
module life_step_engine #(
  parameter int WRAP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [5:0]  load_addr,
  input  logic        load_bit,
  input  logic        step,
  input  logic [5:0]  rd_addr,
  output logic        rd_bit,
  output logic        busy,
  output logic        done,
  output logic [15:0] gen_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] cur;
  logic [63:0] nxt;
  logic [5:0]  idx;
  logic [15:0] gen_q;
  logic        done_q;

  // Neighbourhood evaluation for the cell at idx.
  logic [2:0]  col;
  logic [2:0]  row;
  logic [4:0]  nc;
  logic [4:0]  nr;
  logic        in_board;
  logic [3:0]  sum;
  logic        cell_next;

  assign col = idx[5:3];
  assign row = idx[2:0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> COMPUTE on step, COMPUTE -> COMMIT after cell 63.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (step) state_nxt = COMPUTE;
      COMPUTE: if (idx == 6'd63) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Neighbour count. Coordinates are formed in 5 bits so that col-1 at col 0
  // becomes 31: the low 3 bits give the toroidal coordinate, and any set bit
  // in [4:3] marks an off-board neighbour. The sum is 4 bits so that eight
  // live neighbours cannot alias to zero.
  always_comb begin
    sum      = 4'd0;
    nc       = 5'd0;
    nr       = 5'd0;
    in_board = 1'b0;
    for (int dc = -1; dc <= 1; dc++) begin
      for (int dr = -1; dr <= 1; dr++) begin
        if (dc != 0 || dr != 0) begin
          nc       = {2'b00, col} + 5'(dc);
          nr       = {2'b00, row} + 5'(dr);
          in_board = (nc[4:3] == 2'b00) && (nr[4:3] == 2'b00);
          if (WRAP != 0 || in_board) begin
            sum = sum + {3'b000, cur[{nc[2:0], nr[2:0]}]};
          end
        end
      end
    end
    cell_next = (sum == 4'd3) | (cur[idx] & (sum == 4'd2));
  end

  // Board storage, cell counter, generation counter and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur    <= 64'd0;
      nxt    <= 64'd0;
      idx    <= 6'd0;
      gen_q  <= 16'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (load_en) cur[load_addr] <= load_bit;
          if (step) idx <= 6'd0;
        end
        COMPUTE: begin
          nxt[idx] <= cell_next;
          idx      <= idx + 6'd1;
        end
        COMMIT: begin
          cur    <= nxt;
          gen_q  <= gen_q + 16'd1;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_bit    = cur[rd_addr];
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign gen_count = gen_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_life_step_engine.sv
// tb_life_step_engine: drives a WRAP=0 and a WRAP=1 engine with identical
// stimulus. Each step pushes the expected {gen_count, board} into a per-
// instance queue; a monitor pops and compares whenever done pulses.
module tb_life_step_engine;
  timeunit 1ns;
  timeprecision 100ps;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [5:0]  load_addr;
  logic        load_bit;
  logic        step;
  logic [5:0]  rd_addr;
  logic [1:0]  rd_bit_w;
  logic [1:0]  busy_w;
  logic [1:0]  done_w;
  logic [15:0] gc_w [2];
  logic [1:0]  st_w [2];

  int checks   = 0;
  int failures = 0;

  logic [79:0] exp_q0[$];
  logic [79:0] exp_q1[$];
  logic [63:0] mcur [2];
  logic [15:0] mgc;

  always #10 clk = ~clk;

  life_step_engine #(.WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_bit(load_bit), .step(step), .rd_addr(rd_addr), .rd_bit(rd_bit_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .gen_count(gc_w[0]), .dbg_state(st_w[0])
  );

  life_step_engine #(.WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_bit(load_bit), .step(step), .rd_addr(rd_addr), .rd_bit(rd_bit_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .gen_count(gc_w[1]), .dbg_state(st_w[1])
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] life_ref(input logic [63:0] b, input int wrap);
    logic [63:0] nb;
    int n, cc, rr;
    nb = '0;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        n = 0;
        for (int dc = -1; dc <= 1; dc++) begin
          for (int dr = -1; dr <= 1; dr++) begin
            if (dc != 0 || dr != 0) begin
              cc = c + dc;
              rr = r + dr;
              if (wrap != 0) begin
                cc = (cc + 8) % 8;
                rr = (rr + 8) % 8;
              end
              if (cc >= 0 && cc < 8 && rr >= 0 && rr < 8) n += int'(b[cc*8+rr]);
            end
          end
        end
        nb[c*8+r] = (n == 3) || (b[c*8+r] && n == 2);
      end
    end
    return nb;
  endfunction

  function automatic logic [63:0] cells(input int a, input int b, input int c);
    logic [63:0] r;
    r = '0;
    r[a] = 1'b1;
    r[b] = 1'b1;
    r[c] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [63:0] act [2];
    logic [79:0] e;
    forever begin
      @(negedge clk);
      if (!reset && done_w != 2'b00) begin
        for (int a = 0; a < 64; a++) begin
          rd_addr = 6'(a);
          #0.1;
          act[0][a] = rd_bit_w[0];
          act[1][a] = rd_bit_w[1];
        end
        for (int w = 0; w < 2; w++) begin
          if (done_w[w]) begin
            if ((w == 0 && exp_q0.size() == 0) || (w == 1 && exp_q1.size() == 0)) begin
              checks++;
              failures++;
              $display("FAIL unexpected_done dut%0d actual=done required=no_done", w);
            end else begin
              e = (w == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              chk($sformatf("board_w%0d", w), 80'(act[w]), 80'(e[63:0]));
              chk($sformatf("gen_count_w%0d", w), 80'(gc_w[w]), 80'(e[79:64]));
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mcur[0] = '0;
    mcur[1] = '0;
    mgc = '0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic load_cell(input int a, input logic b);
    load_en   = 1'b1;
    load_addr = 6'(a);
    load_bit  = b;
    @(posedge clk); #1;
    load_en = 1'b0;
    mcur[0][a] = b;
    mcur[1][a] = b;
  endtask

  task automatic sweep(output logic [63:0] b0, output logic [63:0] b1);
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      #0.1;
      b0[a] = rd_bit_w[0];
      b1[a] = rd_bit_w[1];
    end
  endtask

  task automatic push_exp();
    exp_q0.push_back({mgc, mcur[0]});
    exp_q1.push_back({mgc, mcur[1]});
  endtask

  // One generation; optional same-cycle load; expected board either from the
  // model or from constants given by the caller.
  task automatic do_step(input bit wl, input int la, input logic lb, input bit uc,
                         input logic [63:0] c0, input logic [63:0] c1, input string tag);
    if (wl) begin
      load_en   = 1'b1;
      load_addr = 6'(la);
      load_bit  = lb;
      mcur[0][la] = lb;
      mcur[1][la] = lb;
    end
    step = 1'b1;
    @(posedge clk); #1;
    step    = 1'b0;
    load_en = 1'b0;
    mcur[0] = uc ? c0 : life_ref(mcur[0], 0);
    mcur[1] = uc ? c1 : life_ref(mcur[1], 1);
    mgc     = mgc + 16'd1;
    push_exp();
    repeat (66) @(posedge clk);
    #1;
    chk({tag, "_drained"}, 80'(exp_q0.size() + exp_q1.size()), 80'(0));
  endtask

  // Busy length, done pulse count, ignored load/step, stable display.
  task automatic latency_test();
    int bcnt, dcnt, rchg;
    logic [1:0] r0;
    bcnt = 0;
    dcnt = 0;
    rchg = 0;
    step = 1'b1;
    @(posedge clk); #1;
    step    = 1'b0;
    mcur[0] = life_ref(mcur[0], 0);
    mcur[1] = life_ref(mcur[1], 1);
    mgc     = mgc + 16'd1;
    push_exp();
    rd_addr = 6'd19;
    #0.1;
    r0 = rd_bit_w;
    for (int i = 0; i < 80; i++) begin
      if (i == 5) begin
        load_en = 1'b1; load_addr = 6'd5; load_bit = 1'b1;
      end
      if (i == 6) load_en = 1'b0;
      if (i == 10) step = 1'b1;
      if (i == 11) step = 1'b0;
      rd_addr = 6'd19;
      #0.1;
      for (int w = 0; w < 2; w++) begin
        if (busy_w[w]) bcnt++;
        if (done_w[w]) dcnt++;
        if (i < 65 && rd_bit_w[w] !== r0[w]) rchg++;
      end
      @(posedge clk); #1;
    end
    chk("busy_cycles_x2", 80'(bcnt), 80'(130));
    chk("done_pulses_x2", 80'(dcnt), 80'(2));
    chk("rd19_changes_in_compute", 80'(rchg), 80'(0));
    chk("latency_drained", 80'(exp_q0.size() + exp_q1.size()), 80'(0));
  endtask

  task automatic reset_mid_test();
    logic [63:0] b0, b1;
    int dcnt;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    sweep(b0, b1);
    chk("midrst_board_w0", 80'(b0), 80'(0));
    chk("midrst_board_w1", 80'(b1), 80'(0));
    chk("midrst_busy", 80'(busy_w), 80'(0));
    chk("midrst_done", 80'(done_w), 80'(0));
    chk("midrst_gc_w0", 80'(gc_w[0]), 80'(0));
    chk("midrst_gc_w1", 80'(gc_w[1]), 80'(0));
    reset = 1'b0;
    mcur[0] = '0;
    mcur[1] = '0;
    mgc = '0;
    exp_q0.delete();
    exp_q1.delete();
    dcnt = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done_w != 2'b00) dcnt++;
    end
    chk("midrst_no_done", 80'(dcnt), 80'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] b0, b1, ring, still;
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_bit = 1'b0;
    step = 1'b0; rd_addr = '0;
    mcur[0] = '0; mcur[1] = '0; mgc = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // reset state
    sweep(b0, b1);
    chk("rst_board_w0", 80'(b0), 80'(0));
    chk("rst_board_w1", 80'(b1), 80'(0));
    chk("rst_busy", 80'(busy_w), 80'(0));
    chk("rst_done", 80'(done_w), 80'(0));
    chk("rst_gc_w0", 80'(gc_w[0]), 80'(0));
    chk("rst_gc_w1", 80'(gc_w[1]), 80'(0));

    // blinker, two generations
    load_cell(19, 1'b1); load_cell(27, 1'b1); load_cell(35, 1'b1);
    do_step(0, 0, 1'b0, 1, cells(26, 27, 28), cells(26, 27, 28), "blinker1");
    do_step(0, 0, 1'b0, 1, cells(19, 27, 35), cells(19, 27, 35), "blinker2");

    // latency and ignore rules on the blinker
    latency_test();

    // eight-neighbour block
    apply_reset();
    for (int c = 2; c <= 4; c++)
      for (int r = 2; r <= 4; r++) load_cell(c*8 + r, 1'b1);
    ring = cells(11, 18, 20) | cells(25, 29, 34) | cells(36, 43, 43);
    do_step(0, 0, 1'b0, 1, ring, ring, "block3x3");
    rd_addr = 6'd27;
    #0.1;
    chk("center27_dead", 80'(rd_bit_w), 80'(0));

    // wrap check
    apply_reset();
    load_cell(56, 1'b1); load_cell(0, 1'b1); load_cell(8, 1'b1);
    do_step(0, 0, 1'b0, 1, 64'd0, cells(7, 0, 1), "wrap");

    // reset in the middle of a generation
    apply_reset();
    load_cell(19, 1'b1); load_cell(27, 1'b1); load_cell(35, 1'b1);
    do_step(0, 0, 1'b0, 1, cells(26, 27, 28), cells(26, 27, 28), "pre_midrst");
    reset_mid_test();

    // still life keeps its shape while gen_count advances
    apply_reset();
    still = cells(18, 19, 26) | cells(27, 27, 27);
    load_cell(18, 1'b1); load_cell(19, 1'b1); load_cell(26, 1'b1); load_cell(27, 1'b1);
    for (int s = 0; s < 4; s++) do_step(0, 0, 1'b0, 1, still, still, "still");

    // random boards; last cell loaded in the same cycle as the step
    for (int rnd = 0; rnd < 4; rnd++) begin
      apply_reset();
      for (int a = 0; a < 63; a++) load_cell(a, 1'($urandom_range(0, 1)));
      do_step(1, 63, 1'($urandom_range(0, 1)), 0, 64'd0, 64'd0, "rand_load_step");
      do_step(0, 0, 1'b0, 0, 64'd0, 64'd0, "rand_2");
      do_step(0, 0, 1'b0, 0, 64'd0, 64'd0, "rand_3");
    end

    chk("final_drained", 80'(exp_q0.size() + exp_q1.size()), 80'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
